// File: rtl/noc_params.sv
// ============================================================================
// Module      : noc_params (package)
// Description : Shared router parameters: default flit/buffer sizes, flit type
//               codes, type-field width and a constant clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_params;

  localparam int DEF_FLIT_SIZE   = 8;
  localparam int DEF_BUFFER_SIZE = 8;

  // The flit type occupies the top TYPE_W bits: [FLIT_SIZE-1:FLIT_SIZE-2]
  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_HEAD     = 2'b00,
    FLIT_BODY     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  // Ceiling log2, used for elaboration-time widths
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_receiver_if.sv
// ============================================================================
// Module      : link_receiver_if
// Description : Link-side and buffer-side signal bundle of the link receiver.
//               slave = receiver view, master = link/buffer environment view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface link_receiver_if #(
  parameter int FLIT_SIZE = noc_params::DEF_FLIT_SIZE
);

  logic [FLIT_SIZE-1:0] flit_i;
  logic                 valid_i;
  logic                 buf_read_i;
  logic                 buf_full_i;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 write_o;
  logic                 credit_o;

  modport master (
    output flit_i, valid_i, buf_read_i, buf_full_i,
    input  data_o, write_o, credit_o
  );

  modport slave (
    input  flit_i, valid_i, buf_read_i, buf_full_i,
    output data_o, write_o, credit_o
  );

endinterface

`default_nettype wire

// File: rtl/skid_fifo.sv
// ============================================================================
// Module      : skid_fifo
// Description : 2-entry staging FIFO. head reads 0 while empty. The parent
//               only pushes when there is room (not full, or popping).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/link_receiver.sv
// ============================================================================
// Module      : link_receiver
// Description : Router input-port front end. Checks packet framing, stages
//               flits in a 2-entry skid FIFO, writes them into the downstream
//               circular buffer when it will accept, and returns credits.
//               Build option: LINK_RX_FRAMING_CHECK_EN enables the framing FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_receiver
  import noc_params::*;
#(
  parameter int FLIT_SIZE   = DEF_FLIT_SIZE,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  link_receiver_if.slave    link,
  output logic              error_o,
  output logic              packet_active_o
);

  localparam int CW = clog2(BUFFER_SIZE + 1);

  logic                 q_empty;
  logic                 q_full;
  logic [FLIT_SIZE-1:0] q_head;
  logic                 pop;
  logic                 push;
  logic                 no_room;
  logic                 violation;
  logic                 drop;

  logic [CW-1:0]        pending;
  logic [CW-1:0]        pending_d;
  logic                 credit_q;
  logic                 credit_d;
  logic                 error_q;

  // A write is only issued when the buffer will really take it; a write that
  // coincides with a read would be ignored, so the head is held instead.
  assign pop     = ~q_empty & ~link.buf_read_i & ~link.buf_full_i;
  assign no_room = q_full & ~pop;
  assign push    = link.valid_i & ~violation & ~no_room;
  assign drop    = link.valid_i & (violation | no_room);

  assign link.write_o  = pop;
  assign link.data_o   = q_head;
  assign link.credit_o = credit_q;
  assign error_o       = error_q;

  skid_fifo #(
    .WIDTH (FLIT_SIZE)
  ) u_skid_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (link.flit_i),
    .head  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

`ifdef LINK_RX_FRAMING_CHECK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_PACKET = 1'b1;

  logic [0:0] state_q;
  logic [0:0] state_d;
  flit_type_e ftype;

  assign ftype = flit_type_e'(link.flit_i[FLIT_SIZE-1 -: TYPE_W]);

  // Framing state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: only an accepted (staged) flit advances the framing
  always_comb begin
    state_d = state_q;
    if (push) begin
      case (state_q)
        ST_IDLE:   if (ftype == FLIT_HEAD) state_d = ST_PACKET;
        ST_PACKET: if (ftype == FLIT_TAIL) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: packet indicator and framing-violation decode
  always_comb begin
    packet_active_o = (state_q == ST_PACKET);
    violation       = 1'b0;
    if (link.valid_i) begin
      if (state_q == ST_IDLE)
        violation = (ftype == FLIT_BODY) || (ftype == FLIT_TAIL);
      else
        violation = (ftype == FLIT_HEAD) || (ftype == FLIT_HEADTAIL);
    end
  end
`else
  assign violation       = 1'b0;
  assign packet_active_o = 1'b0;
`endif

  // Credit accounting: add this cycle's read and drop, emit one pulse if
  // anything is owed, keep the remainder (saturating at the buffer depth)
  always_comb begin
    logic [CW:0] owed;
    logic [CW:0] left;
    owed     = {1'b0, pending} + (CW+1)'(link.buf_read_i) + (CW+1)'(drop);
    credit_d = (owed != '0);
    left     = owed - (CW+1)'(credit_d);
    if (left > (CW+1)'(BUFFER_SIZE)) pending_d = CW'(BUFFER_SIZE);
    else                             pending_d = left[CW-1:0];
  end

  // Credit and sticky-error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      credit_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      pending  <= pending_d;
      credit_q <= credit_d;
      error_q  <= error_q | drop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_link_receiver.sv
// ============================================================================
// Module      : tb_link_receiver
// Description : Self-checking bench for link_receiver: directed vector table,
//               hand-written corner sequences and randomized traffic against
//               a queue-based reference model. Honours LINK_RX_FRAMING_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_link_receiver;
  import noc_params::*;

  localparam int FW = 8;
  localparam int BS = 8;
`ifdef LINK_RX_FRAMING_CHECK_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic error;
  logic active;

  link_receiver_if #(.FLIT_SIZE(FW)) lif();

  link_receiver #(
    .FLIT_SIZE   (FW),
    .BUFFER_SIZE (BS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .link            (lif.slave),
    .error_o         (error),
    .packet_active_o (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: staged flits, framing flag, owed credits, sticky error
  logic [FW-1:0] mq[$];
  bit            m_in_pkt;
  int            m_pending;
  bit            m_credit;
  bit            m_error;

  // Inputs of the cycle in progress
  bit            cur_r, cur_v, cur_rd, cur_fl;
  logic [FW-1:0] cur_f;

  typedef struct {
    bit            v;
    logic [FW-1:0] f;
    bit            rd;
    bit            fl;
    bit            e_write;
    logic [FW-1:0] e_data;
    bit            e_credit;
    bit            e_error;
    bit            e_active;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_in_pkt  = 1'b0;
    m_pending = 0;
    m_credit  = 1'b0;
    m_error   = 1'b0;
  endfunction

  function automatic bit m_write(input bit rd, input bit fl);
    return (mq.size() > 0) && !rd && !fl;
  endfunction

  function automatic logic [FW-1:0] m_data();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  function automatic bit m_legal(input logic [FW-1:0] f);
    logic [1:0] t;
    t = f[FW-1:FW-2];
    if (!FRAMING) return 1'b1;
    if (m_in_pkt) return (t == FLIT_BODY) || (t == FLIT_TAIL);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  // Advance the model across one clock edge using the current inputs
  function automatic void model_edge();
    bit drop;
    int owed;
    logic [1:0] t;
    if (cur_r) begin
      model_reset();
      return;
    end
    drop = 1'b0;
    if (m_write(cur_rd, cur_fl)) void'(mq.pop_front());
    if (cur_v) begin
      t = cur_f[FW-1:FW-2];
      if (!m_legal(cur_f) || mq.size() >= 2) begin
        drop = 1'b1;
      end else begin
        mq.push_back(cur_f);
        if (FRAMING && t == FLIT_HEAD) m_in_pkt = 1'b1;
        if (FRAMING && t == FLIT_TAIL) m_in_pkt = 1'b0;
      end
    end
    if (drop) m_error = 1'b1;
    owed     = m_pending + int'(cur_rd) + int'(drop);
    m_credit = (owed > 0);
    if (m_credit) owed = owed - 1;
    m_pending = (owed > BS) ? BS : owed;
  endfunction

  // Apply inputs, wait to the falling edge and compare against the model
  task automatic drive_sample(input bit r, input bit v, input logic [FW-1:0] f,
                              input bit rd, input bit fl);
    cur_r = r; cur_v = v; cur_f = f; cur_rd = rd; cur_fl = fl;
    rst            = r;
    lif.valid_i    = v;
    lif.flit_i     = f;
    lif.buf_read_i = rd;
    lif.buf_full_i = fl;
    @(negedge clk);
    check("model write_o", lif.write_o, m_write(rd, fl));
    check("model data_o", lif.data_o, m_data());
    check("model credit_o", lif.credit_o, m_credit);
    check("model error_o", error, m_error);
    check("model packet_active_o", active, FRAMING ? m_in_pkt : 1'b0);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(input bit r, input bit v, input logic [FW-1:0] f,
                       input bit rd, input bit fl);
    drive_sample(r, v, f, rd, fl);
    finish_cycle();
  endtask

  task automatic reset_dut();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [1:0] pick_type();
    if ($urandom_range(0, 99) < 15) return 2'($urandom_range(0, 3));
    if (m_in_pkt) return ($urandom_range(0, 1) != 0) ? 2'(FLIT_BODY) : 2'(FLIT_TAIL);
    return ($urandom_range(0, 1) != 0) ? 2'(FLIT_HEAD) : 2'(FLIT_HEADTAIL);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            v  flit   rd fl | wr data   cr er act
    tbl[0]  = '{1, 8'h05, 0, 0,   0, 8'h00, 0, 0, 0};
    tbl[1]  = '{1, 8'h4A, 0, 0,   1, 8'h05, 0, 0, 1};
    tbl[2]  = '{1, 8'h4B, 0, 0,   1, 8'h4A, 0, 0, 1};
    tbl[3]  = '{1, 8'h8C, 0, 0,   1, 8'h4B, 0, 0, 1};
    tbl[4]  = '{0, 8'h00, 0, 0,   1, 8'h8C, 0, 0, 0};
    tbl[5]  = '{1, 8'hC1, 0, 0,   0, 8'h00, 0, 0, 0};
    tbl[6]  = '{0, 8'h00, 1, 0,   0, 8'hC1, 0, 0, 0};
    tbl[7]  = '{0, 8'h00, 1, 0,   0, 8'hC1, 1, 0, 0};
    tbl[8]  = '{0, 8'h00, 1, 0,   0, 8'hC1, 1, 0, 0};
    tbl[9]  = '{0, 8'h00, 0, 0,   1, 8'hC1, 1, 0, 0};
    tbl[10] = '{0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0};

    rst = 1'b1;
    lif.valid_i = 1'b0; lif.flit_i = '0; lif.buf_read_i = 1'b0; lif.buf_full_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("reset write_o", lif.write_o, 0);
    check("reset data_o", lif.data_o, 0);
    check("reset credit_o", lif.credit_o, 0);
    check("reset error_o", error, 0);
    check("reset packet_active_o", active, 0);
    finish_cycle();

    // Directed vector table: packet streaming, then a read-blocked flit
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      drive_sample(1'b0, tbl[i].v, tbl[i].f, tbl[i].rd, tbl[i].fl);
      check("tbl write_o", lif.write_o, tbl[i].e_write);
      check("tbl data_o", lif.data_o, tbl[i].e_data);
      check("tbl credit_o", lif.credit_o, tbl[i].e_credit);
      check("tbl error_o", error, tbl[i].e_error);
      check("tbl packet_active_o", active, tbl[i].e_active & FRAMING);
      finish_cycle();
    end

    // BODY while IDLE
    reset_dut();
    cycle(1'b0, 1'b1, 8'h4A, 1'b0, 1'b0);
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("idle body write_o", lif.write_o, FRAMING ? 0 : 1);
    check("idle body error_o", error, FRAMING ? 1 : 0);
    check("idle body credit_o", lif.credit_o, FRAMING ? 1 : 0);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("idle body single credit", lif.credit_o, 0);
    finish_cycle();

    // Buffer full: two held, third dropped, held pair drains in order
    reset_dut();
    cycle(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hC2, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("overflow error_o", error, 1);
    check("overflow credit_o", lif.credit_o, 1);
    check("overflow held write_o", lif.write_o, 0);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("drain first write_o", lif.write_o, 1);
    check("drain first data_o", lif.data_o, 8'hC1);
    check("drain single credit", lif.credit_o, 0);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("drain second data_o", lif.data_o, 8'hC2);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("drained write_o", lif.write_o, 0);
    finish_cycle();

    // Read and drop in the same cycle: two consecutive credit pulses
    reset_dut();
    cycle(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hC2, 1'b0, 1'b1);
    drive_sample(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
    check("read+drop same-cycle credit_o", lif.credit_o, 0);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("read+drop pulse 1", lif.credit_o, 1);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("read+drop pulse 2", lif.credit_o, 1);
    finish_cycle();
    drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("read+drop pulses end", lif.credit_o, 0);
    finish_cycle();

    // Reset mid-packet with flits staged and credits pending
    reset_dut();
    cycle(1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h4A, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h4B, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_sample(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("post-rst write_o", lif.write_o, 0);
      check("post-rst data_o", lif.data_o, 0);
      check("post-rst credit_o", lif.credit_o, 0);
      check("post-rst error_o", error, 0);
      check("post-rst packet_active_o", active, 0);
      finish_cycle();
    end

    // Randomized traffic against the reference model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      bit            r, v, rd, fl;
      logic [FW-1:0] f;
      r  = ($urandom_range(0, 249) == 0);
      v  = ($urandom_range(0, 1) != 0);
      f  = {pick_type(), 6'($urandom_range(0, 63))};
      rd = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 3) == 0);
      cycle(r, v, f, rd, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/link_receiver.md
# link_receiver

Input-port front end of the router: accepts flits from the neighbouring router's link, checks packet framing, stages them in a 2-entry skid queue and writes them into the port's `circular_buffer` only in cycles where the buffer will accept the write. It also turns every buffer read, and every dropped flit, into a one-cycle credit pulse back to the upstream router. It sits directly upstream of `circular_buffer`, and its write side drives the buffer's `data_i` and `write_i`.

## Interface

- `FLIT_SIZE`, default 8: flit width in bits; bits `[FLIT_SIZE-1:FLIT_SIZE-2]` carry the flit type.
- `BUFFER_SIZE`, default 8: depth of the downstream `circular_buffer`; equals the initial upstream credit count.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `flit_i`, input, FLIT_SIZE: flit from the link.
- `valid_i`, input, 1: `flit_i` is valid this cycle; there is no back-pressure, because upstream is credit-limited.
- `buf_read_i`, input, 1: the downstream reader asserts the buffer's `read_i` this cycle; the same net drives the buffer.
- `buf_full_i`, input, 1: the buffer's `full_o`.
- `data_o`, output, FLIT_SIZE: the staging-queue head, driven to the buffer's `data_i`.
- `write_o`, output, 1: write strobe to the buffer's `write_i`.
- `credit_o`, output, 1: one-cycle pulse that returns one credit upstream.
- `error_o`, output, 1: sticky error flag for a framing violation or staging overflow.
- `packet_active_o`, output, 1: framing FSM is in PACKET.

## Operation

- Flit type codes: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
- Framing FSM states are IDLE and PACKET.
  - In IDLE: HEAD moves the FSM to PACKET. HEADTAIL is accepted and the FSM stays in IDLE. BODY or TAIL is a violation.
  - In PACKET: BODY is accepted and the FSM stays. TAIL is accepted and the FSM moves to IDLE. HEAD or HEADTAIL is a violation and the FSM stays in PACKET.
- A violating flit is dropped and never staged. It sets `error_o` and still returns its credit.
- Staging queue: a 2-entry FIFO. An accepted flit is pushed at the clock edge of the cycle in which `valid_i` is high.
- Overflow: `valid_i` with the queue full and no pop in the same cycle. The flit is dropped, `error_o` is set and its credit is returned. The FSM does not advance.
- Write rule: `write_o = queue_nonempty & ~buf_read_i & ~buf_full_i`.
  - The buffer ignores a write that coincides with a read, so a blocked head is held and retried in the next cycle.
  - A write pops the queue head.
  - `data_o` always shows the queue head, or 0 when the queue is empty.
- Credit return uses a pending counter of width `clog2(BUFFER_SIZE+1)`, saturating at `BUFFER_SIZE`.
  - The counter increments for each `buf_read_i` cycle and for each dropped flit. Up to +2 per cycle is possible, when a read and a drop coincide.
  - `credit_o` is registered and is high in any cycle where the counter is nonzero at the preceding edge; each pulse decrements the counter by 1.
- `error_o` is cleared only by `rst`.

## Timing

- Reset values: `write_o`=0, `credit_o`=0, `error_o`=0, `packet_active_o`=0, `data_o`=0. The queue is empty, the FSM is in IDLE and the pending count is 0.
- Latency from `valid_i` to `write_o`: 1 cycle when the buffer is free.
- `write_o` is combinational from `buf_read_i` and `buf_full_i`; it has no register stage.
- Latency from `buf_read_i` or a drop to `credit_o`: 1 cycle. Back-to-back events produce back-to-back pulses.
- `rst` mid-packet clears everything in the same edge. Staged flits and pending credits are discarded; upstream must be reset together with this block.
- `valid_i` arriving in the cycle of a pop is accepted even if the queue was full at the start of that cycle.

## Configuration

- `LINK_RX_FRAMING_CHECK_EN`
  - Defined: the framing FSM and framing violations behave as above.
  - Undefined: the FSM is removed and every flit is accepted regardless of type; `packet_active_o` is tied to 0.
  - Staging-queue overflow still sets `error_o` in both builds.

## Structure

- Shared package `noc_params` holds:
  - `FLIT_SIZE` and `BUFFER_SIZE` defaults;
  - the flit-type enum (HEAD/BODY/TAIL/HEADTAIL) and the type-field bit positions;
  - the `clog2` function, reused by `circular_buffer`.
- One sub-module, `skid_fifo`: a 2-entry FIFO with push, pop, head, empty and full. The FSM and the credit logic stay in `link_receiver`.

## Test plan

- After reset, HEAD, BODY, BODY, TAIL on consecutive cycles with the buffer idle: `write_o` high in cycles 1–4 with the same flits in order; `packet_active_o` high from cycle 1 until the edge after TAIL; `error_o`=0.
- Staged flit with `buf_read_i`=1 for 3 consecutive cycles: `write_o`=0 for those 3 cycles and the flit is written in the 4th; `credit_o` pulses in cycles +1 to +3.
- BODY while IDLE: not written, `error_o`=1 from the next cycle, one `credit_o` pulse. With `LINK_RX_FRAMING_CHECK_EN` undefined, the same BODY is written and `error_o` stays 0.
- `buf_full_i`=1 and three flits arrive: two are held, the third is dropped with `error_o`=1 and one credit returned. When `buf_full_i` falls, the two held flits are written in order.
- `buf_read_i` and a dropped flit in the same cycle: pending count 2, giving `credit_o` high in the next two consecutive cycles.
- `rst` asserted mid-packet with 2 flits staged and 2 credits pending: the next cycle shows all outputs 0 and IDLE; no stale write or credit pulse after `rst` deasserts.
